led_seq_ctrl: RTL and testbench

//  Upstream run controller for the 4-bit step counter and 4:16 LED decoder.

---
 rtl/led_ctrl_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/led_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings and sizing helpers for the LED run controller.
// Optional button debouncing is enabled with LED_CTRL_DEBOUNCE_EN.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_A = 2'b01;
   localparam logic [1:0] MODE_B = 2'b10;
   localparam logic [1:0] MODE_C = 2'b11;

   localparam int DEF_TICK_DIV  = 50_000_000;
   localparam int DEF_RUN_STEPS = 16;
   localparam int DEF_DB_CYCLES = 1_000_000;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Decoder mode never takes the value 00.
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      case (m)
         MODE_A:  return MODE_B;
         MODE_B:  return MODE_C;
         default: return MODE_A;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, optional debouncer, rising-edge pulse.
// The debouncer is built only when LED_CTRL_DEBOUNCE_EN is defined.
module btn_debounce
   import led_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic Clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic level;
   logic level_q;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef LED_CTRL_DEBOUNCE_EN
   localparam int DB_W = cnt_w(DB_CYCLES);

   logic [DB_W-1:0] stable_cnt;
   logic            db_level;

   // A new level is taken only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         stable_cnt <= '0;
         db_level   <= 1'b0;
      end else if (sync2 == db_level) begin
         stable_cnt <= '0;
      end else if (stable_cnt == DB_W'(DB_CYCLES - 1)) begin
         stable_cnt <= '0;
         db_level   <= sync2;
      end else begin
         stable_cnt <= stable_cnt + 1'b1;
      end
   end

   assign level = db_level;
`else
   assign level = sync2;
`endif

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Run controller: buttons -> mode/start/idle, step enable and counter clear.
// Build with LED_CTRL_DEBOUNCE_EN to debounce the buttons (adds DB_CYCLES latency).
module led_seq_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int RUN_STEPS = DEF_RUN_STEPS,
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_mode,
   input  logic       btn_stop,
   output logic       en,
   output logic       cnt_clr,
   output logic       start,
   output logic       idle,
   output logic [1:0] mode,
   output state_t     dbg_state
);

   localparam int PRESC_W = cnt_w(TICK_DIV);
   localparam int STEP_W  = cnt_w(RUN_STEPS + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_PRE  = PRESC_W'(TICK_DIV - 2);
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(RUN_STEPS);

   logic start_rise;
   logic mode_rise;
   logic stop_rise;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .Clk(Clk), .reset(reset), .btn(btn_start), .rise(start_rise));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .Clk(Clk), .reset(reset), .btn(btn_mode), .rise(mode_rise));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
      .Clk(Clk), .reset(reset), .btn(btn_stop), .rise(stop_rise));

   state_t              state, state_nx;
   logic [PRESC_W-1:0]  presc, presc_nx;
   logic [STEP_W-1:0]   step, step_nx;
   logic [1:0]          mode_nx;
   logic                en_nx;
   logic                clr_nx;

   // en is registered, so the tick is decided one cycle early (prescaler at
   // TICK_DIV-2); a stop edge seen in that cycle cancels the pulse.
   always_comb begin
      state_nx = state;
      presc_nx = presc;
      step_nx  = step;
      mode_nx  = mode;
      en_nx    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mode_rise) mode_nx = next_mode(mode);
            if (start_rise && !stop_rise) begin
               state_nx = ST_RUN;
               presc_nx = '0;
               step_nx  = '0;
            end
         end
         ST_RUN: begin
            presc_nx = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            if (stop_rise) begin
               state_nx = ST_IDLE;
            end else if (en && step == STEP_LAST) begin
               state_nx = ST_DONE;
               presc_nx = '0;
            end else if (presc == PRESC_PRE) begin
               en_nx   = 1'b1;
               step_nx = step + 1'b1;
            end
         end
         ST_DONE: begin
            if (mode_rise) mode_nx = next_mode(mode);
            if (stop_rise) begin
               state_nx = ST_IDLE;
            end else if (start_rise) begin
               state_nx = ST_RUN;
               presc_nx = '0;
               step_nx  = '0;
            end else if (presc == PRESC_LAST) begin
               state_nx = ST_IDLE;
            end else begin
               presc_nx = presc + 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      clr_nx = (state_nx == ST_RUN) && (state != ST_RUN);
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         presc   <= '0;
         step    <= '0;
         mode    <= MODE_A;
         en      <= 1'b0;
         cnt_clr <= 1'b0;
         start   <= 1'b0;
         idle    <= 1'b1;
      end else begin
         state   <= state_nx;
         presc   <= presc_nx;
         step    <= step_nx;
         mode    <= mode_nx;
         en      <= en_nx;
         cnt_clr <= clr_nx;
         start   <= (state_nx == ST_RUN);
         idle    <= (state_nx == ST_IDLE);
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4, RUN_STEPS=3, DB_CYCLES=8.
// With LED_CTRL_DEBOUNCE_EN defined only the reset and debounce scenarios run.
module tb_led_seq_ctrl;
   import led_ctrl_pkg::*;

   localparam int TICK_DIV  = 4;
   localparam int RUN_STEPS = 3;
   localparam int DB_CYCLES = 8;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_stop = 1'b0;
   logic       en;
   logic       cnt_clr;
   logic       start;
   logic       idle;
   logic [1:0] mode;
   state_t     dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] exp_q[$];

   led_seq_ctrl #(
      .TICK_DIV(TICK_DIV), .RUN_STEPS(RUN_STEPS), .DB_CYCLES(DB_CYCLES)
   ) dut (
      .Clk(Clk), .reset(reset),
      .btn_start(btn_start), .btn_mode(btn_mode), .btn_stop(btn_stop),
      .en(en), .cnt_clr(cnt_clr), .start(start), .idle(idle),
      .mode(mode), .dbg_state(dbg_state)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic check_outs(input string tag, input logic e, input logic c,
                             input logic s, input logic i, input logic [1:0] m);
      check({tag, ".en"}, en, e);
      check({tag, ".cnt_clr"}, cnt_clr, c);
      check({tag, ".start"}, start, s);
      check({tag, ".idle"}, idle, i);
      check({tag, ".mode"}, mode, m);
   endtask

   // One-cycle raw pulse; returns on the cycle where the response is visible.
   task automatic pulse(input logic s, input logic m, input logic p);
      btn_start = s;
      btn_mode  = m;
      btn_stop  = p;
      cyc(1);
      btn_start = 1'b0;
      btn_mode  = 1'b0;
      btn_stop  = 1'b0;
      cyc(2);
   endtask

   initial begin
      int en_cnt;
      int clr_cnt;

      // Reset held, then released
      cyc(3);
      check_outs("rst_held", 1'b0, 1'b0, 1'b0, 1'b1, MODE_A);
      check("rst_held.state", dbg_state, ST_IDLE);
      reset = 1'b0;
      cyc(4);
      check_outs("rst_rel", 1'b0, 1'b0, 1'b0, 1'b1, MODE_A);

`ifdef LED_CTRL_DEBOUNCE_EN
      // 5-cycle glitch must not start a run
      btn_start = 1'b1;
      cyc(5);
      btn_start = 1'b0;
      en_cnt = 0;
      for (int k = 0; k < 25; k++) begin
         en_cnt += int'(start) + int'(cnt_clr) + int'(!idle);
         cyc(1);
      end
      check("glitch.activity", en_cnt, 0);
      check("glitch.idle", idle, 1'b1);

      // Held press enters RUN DB_CYCLES+3 cycles after the raw rise
      btn_start = 1'b1;
      cyc(DB_CYCLES + 2);
      check("db.start_early", start, 1'b0);
      check("db.idle_early", idle, 1'b1);
      cyc(1);
      check("db.start", start, 1'b1);
      check("db.cnt_clr", cnt_clr, 1'b1);
      check("db.idle", idle, 1'b0);
      cyc(9);
      btn_start = 1'b0;
      cyc(2);
`else
      // Full run: en every TICK_DIV cycles, then DONE for TICK_DIV cycles
      pulse(1'b1, 1'b0, 1'b0);
      en_cnt = 0;
      for (int k = 1; k <= 17; k++) begin
         check_outs($sformatf("run.c%0d", k),
                    (k % TICK_DIV == 0) && (k <= TICK_DIV * RUN_STEPS),
                    k == 1,
                    k <= TICK_DIV * RUN_STEPS,
                    k == 17,
                    MODE_A);
         if (k == 13) check("run.done_state", dbg_state, ST_DONE);
         en_cnt += int'(en);
         if (k < 17) cyc(1);
      end
      check("run.en_total", en_cnt, RUN_STEPS);

      // Mode advances in IDLE, ignored in RUN
      exp_q.push_back(MODE_B);
      exp_q.push_back(MODE_C);
      exp_q.push_back(MODE_A);
      for (int k = 0; k < 3; k++) begin
         pulse(1'b0, 1'b1, 1'b0);
         check($sformatf("mode.adv%0d", k), mode, exp_q.pop_front());
      end
      pulse(1'b1, 1'b0, 1'b0);
      check("mode.run_start", start, 1'b1);
      pulse(1'b0, 1'b1, 1'b0);
      check("mode.run_hold", mode, MODE_A);
      check("mode.run_still", start, 1'b1);
      pulse(1'b0, 1'b0, 1'b1);
      check("stop.idle", idle, 1'b1);
      check("stop.start", start, 1'b0);

      // Stop edge coinciding with the second tick suppresses it
      pulse(1'b1, 1'b0, 1'b0);
      en_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         en_cnt += int'(en);
         if (k == 7) check("tickstop.pre_start", start, 1'b1);
         if (k == 8) check_outs("tickstop.c8", 1'b0, 1'b0, 1'b0, 1'b1, MODE_A);
         if (k == 5) btn_stop = 1'b1;
         if (k == 6) btn_stop = 1'b0;
         cyc(1);
      end
      check("tickstop.en_total", en_cnt, 1);

      // Start+mode together; reset mid-run aborts at once
      pulse(1'b1, 1'b1, 1'b0);
      check_outs("startmode", 1'b0, 1'b1, 1'b1, 1'b0, MODE_B);
      cyc(5);
      #2 reset = 1'b1;
      #1 check_outs("midrst", 1'b0, 1'b0, 1'b0, 1'b1, MODE_A);
      cyc(2);
      reset = 1'b0;
      en_cnt = 0;
      clr_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         cyc(1);
         en_cnt  += int'(en);
         clr_cnt += int'(cnt_clr);
      end
      check("midrst.en_after", en_cnt, 0);
      check("midrst.clr_after", clr_cnt, 0);
      check("midrst.idle_after", idle, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
